// File: rtl/pb_reset_debounce.sv
// Reset push-button conditioner: synchronizes and debounces the raw button, and emits
// level/edge strobes plus a fixed-width rst_req pulse on every accepted press.
module pb_reset_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_rise,
    output logic pb_fall,
    output logic rst_req
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [PCNT_W-1:0]      pcnt;
    logic                   accept_rise, accept_fall, level_nxt;

    // Input synchronizer: pb_in is asynchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pb_in};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync_q) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE_HIGH;
                    cnt_nxt     = '0;
                    accept_rise = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE_LOW;
                    cnt_nxt     = '0;
                    accept_fall = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level follows the state being entered, so it updates on the transition edge itself
    assign level_nxt = (state_nxt == IDLE_HIGH) || (state_nxt == WAIT_LOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_level <= 1'b0;
            pb_rise  <= 1'b0;
            pb_fall  <= 1'b0;
        end else begin
            pb_level <= level_nxt;
            pb_rise  <= accept_rise;
            pb_fall  <= accept_fall;
        end
    end

    // Pulse stretcher; a press during an active pulse simply reloads the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt    <= '0;
            rst_req <= 1'b0;
        end else if (accept_rise) begin
            pcnt    <= PCNT_LOAD;
            rst_req <= 1'b1;
        end else if (pcnt != '0) begin
            pcnt <= pcnt - 1'b1;
            if (pcnt == PCNT_ONE) begin
                rst_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_reset_debounce.sv
// Directed bench for pb_reset_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=8, PULSE_CYCLES=4.
// Expected outputs are packed as {pb_level, pb_rise, pb_fall, rst_req}.
module tb_pb_reset_debounce;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pb_in = 1'b0;
    logic pb_level, pb_rise, pb_fall, rst_req;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       rst_v;
        logic       pb_v;
        logic [3:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    pb_reset_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .PULSE_CYCLES   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_in   (pb_in),
        .pb_level(pb_level),
        .pb_rise (pb_rise),
        .pb_fall (pb_fall),
        .rst_req (rst_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] exp);
        logic [3:0] act;
        act = {pb_level, pb_rise, pb_fall, rst_req};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got lvl/rise/fall/req=%b required %b at %0t", nm, act, exp, $time);
    endtask

    // Drive on the falling edge, compare shortly after the following rising edge
    task automatic apply(input logic r, input logic p, input logic [3:0] exp, input string nm);
        @(negedge clk);
        rst   = r;
        pb_in = p;
        @(posedge clk);
        #1;
        check(nm, exp);
    endtask

    task automatic settle(input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            pb_in = p;
        end
    endtask

    function automatic void add(input logic r, input logic p, input logic [3:0] e, input string t);
        vec_t v;
        v.rst_v = r;
        v.pb_v  = p;
        v.exp   = e;
        v.tag   = t;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset held with the button chattering, then released with the button idle
        for (int i = 0; i < 6; i++) add(1'b0, logic'(i % 2), 4'b0000, "reset_hold");
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 4'b0000, "reset_release");
        // Clean press: edges 1..10 quiet, accepted at 11, pulse ends at 15
        for (int i = 1; i <= 10; i++) add(1'b1, 1'b1, 4'b0000, "press_wait");
        add(1'b1, 1'b1, 4'b1101, "press_edge11");
        add(1'b1, 1'b1, 4'b1001, "press_edge12");
        add(1'b1, 1'b1, 4'b1001, "press_edge13");
        add(1'b1, 1'b1, 4'b1001, "press_edge14");
        add(1'b1, 1'b1, 4'b1000, "press_edge15");
        add(1'b1, 1'b1, 4'b1000, "press_edge16");
        // Release: level held through edge 10, fall strobe at 11
        for (int i = 1; i <= 10; i++) add(1'b1, 1'b0, 4'b1000, "release_wait");
        add(1'b1, 1'b0, 4'b0010, "release_edge11");
        add(1'b1, 1'b0, 4'b0000, "release_edge12");
        add(1'b1, 1'b0, 4'b0000, "release_edge13");

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].rst_v, vecs[i].pb_v, vecs[i].exp, $sformatf("%s[%0d]", vecs[i].tag, i));

        // Bounce: high 5, low 1, then held; qualification restarts, accepted at edge 17
        for (int e = 1; e <= 22; e++) begin
            logic [3:0] x;
            if (e <= 16) x = 4'b0000;
            else if (e == 17) x = 4'b1101;
            else if (e <= 20) x = 4'b1001;
            else x = 4'b1000;
            apply(1'b1, (e == 6) ? 1'b0 : 1'b1, x, $sformatf("bounce_e%0d", e));
        end
        settle(1'b0, 14);

        // Short pulse of 7 cycles never qualifies
        for (int e = 1; e <= 18; e++)
            apply(1'b1, (e <= 7) ? 1'b1 : 1'b0, 4'b0000, $sformatf("short_e%0d", e));

        // Press, then reset two cycles into the rst_req pulse
        for (int e = 1; e <= 13; e++) begin
            logic [3:0] x;
            if (e <= 10) x = 4'b0000;
            else if (e == 11) x = 4'b1101;
            else x = 4'b1001;
            apply(1'b1, 1'b1, x, $sformatf("midrst_press_e%0d", e));
        end
        #1;
        rst = 1'b0;
        #1;
        check("midrst_async_drop", 4'b0000);
        apply(1'b0, 1'b1, 4'b0000, "midrst_hold0");
        apply(1'b0, 1'b1, 4'b0000, "midrst_hold1");
        // Button still held at reset release: fresh press accepted 11 edges later
        for (int e = 1; e <= 12; e++) begin
            logic [3:0] x;
            if (e <= 10) x = 4'b0000;
            else if (e == 11) x = 4'b1101;
            else x = 4'b1001;
            apply(1'b1, 1'b1, x, $sformatf("midrst_repress_e%0d", e));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pb_reset_debounce.md
# pb_reset_debounce

Conditions the raw, bouncing reset push-button of the Full UART board into clean control signals. It sits directly upstream of the reset synchronizer. Its `rst_req` output drives the synchronizer's active-high asynchronous `rst` input, which guarantees a glitch-free reset pulse of known minimum width. It also exposes debounced level and edge strobes for general use.

## Interface
- `SYNC_STAGES`, 2: number of input synchronizer flops (legal range 2–4).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a level change (≥2; 5 ms at 100 MHz).
- `PULSE_CYCLES`, 16: width of the `rst_req` pulse in clocks (≥1).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (logic 0 resets the block immediately, independent of `clk`).
- `pb_in`  in  1  raw push-button level, asynchronous to `clk`, active-high (1 = pressed).
- `pb_level`  out  1  debounced, registered button level.
- `pb_rise`  out  1  one-clock strobe on accepted press.
- `pb_fall`  out  1  one-clock strobe on accepted release.
- `rst_req`  out  1  active-high reset request, `PULSE_CYCLES` clocks wide, feeding the reset synchronizer.

## Operation
- **Synchronizer:** `pb_in` passes through a `SYNC_STAGES`-deep flop chain. Only its last stage, `sync_q`, is used downstream.
- **Debounce counter:** `cnt` has width clog2(`DEBOUNCE_CYCLES`) and is unsigned.
- **FSM states:** IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: if `sync_q`=1, go to WAIT_HIGH with `cnt`←0.
  - WAIT_HIGH: if `sync_q`=0, return to IDLE_LOW (bounce rejected, `cnt`←0). Else, if `cnt`=`DEBOUNCE_CYCLES`−1, go to IDLE_HIGH. Else `cnt`←`cnt`+1.
  - IDLE_HIGH: if `sync_q`=0, go to WAIT_LOW with `cnt`←0.
  - WAIT_LOW: mirror of WAIT_HIGH. On `sync_q`=1, return to IDLE_HIGH. On terminal count, go to IDLE_LOW.
- **`pb_level`:** 1 in IDLE_HIGH and WAIT_LOW; 0 otherwise. It is registered and changes on the same edge as the transition.
- **Strobes:**
  - `pb_rise`=1 for exactly the one cycle following the WAIT_HIGH→IDLE_HIGH transition.
  - `pb_fall`=1 for exactly the one cycle following the WAIT_LOW→IDLE_LOW transition.
  - The two strobes are never both 1.
- **Pulse stretcher:**
  - Every accepted press (same edge that sets `pb_rise`) loads `pcnt`←`PULSE_CYCLES` and sets `rst_req`=1.
  - `pcnt` decrements each cycle while nonzero. `rst_req` clears on the edge where `pcnt` goes 1→0.
  - A new accepted press while `pcnt`≠0 reloads `pcnt` (retrigger). This can occur only when `DEBOUNCE_CYCLES`·2 < `PULSE_CYCLES`.
- **Counter rule:** `cnt` never wraps. The terminal compare exits WAIT states before overflow.
- **Release:** release never affects `rst_req`.

## Timing
- **Reset (`rst`=0):** sync flops=0, state=IDLE_LOW, `cnt`=0, `pcnt`=0. `pb_level`=0, `pb_rise`=0, `pb_fall`=0, `rst_req`=0, all asynchronously.
- **Reset mid-operation:** all activity aborts, including a `rst_req` pulse in progress, which drops immediately.
- **Button held at reset release:** the press is debounced normally and produces `pb_rise` and `rst_req`.
- **Press latency:** `pb_in` goes high and is stable before edge 1.
  - `sync_q`=1 after edge `SYNC_STAGES`.
  - WAIT_HIGH is entered at edge `SYNC_STAGES`+1.
  - `pb_level`, `pb_rise` and `rst_req` rise after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1.
  - `pb_rise` falls one edge later.
  - `rst_req` falls `PULSE_CYCLES` edges after it rose.
- **Release latency:** identical, applied to `pb_level`/`pb_fall`.
- **Bounce:** any opposite sample in a WAIT state restarts qualification from the next stable sample. The accepted edge is therefore delayed by the full bounce duration.
- **No combinational path** from `pb_in` to any output.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8, `PULSE_CYCLES`=4.
- **Reset values:** hold `rst`=0 with `pb_in` toggling → all outputs 0 throughout. Release `rst` with `pb_in`=0 → outputs stay 0.
- **Clean press:** `pb_in`↑ before edge 1, held → `pb_level`/`pb_rise`/`rst_req`=1 after edge 11. `pb_rise`=0 after edge 12. `rst_req`=0 after edge 15.
- **Bounce rejection:** `pb_in` high 5 cycles, low 1, then high and held → no strobe during the glitch. `pb_rise` occurs 8 WAIT cycles after the last 0→1 sample.
- **Short pulse:** `pb_in` high for 7 cycles, then low → no `pb_rise`, no `rst_req`, `pb_level` stays 0.
- **Release:** after an accepted press, `pb_in`↓ held → `pb_fall` one cycle, 11 edges later. `pb_level`→0 on that edge. `rst_req` unaffected.
- **Mid-pulse reset:** assert `rst`=0 two cycles after `rst_req` rises → `rst_req` drops immediately. After `rst` releases with the button still held → a fresh `pb_rise` 11 edges later.
